tile_grid_renderer: RTL and testbench



---
 rtl/tile_grid_renderer_if.sv | 35 +++
 rtl/tile_grid_renderer.sv | 152 +++++++++++++++
 tb/tb_tile_grid_renderer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/tile_grid_renderer_if.sv
// tile_grid_renderer_if: bus between the VGA timing/game side and the tile renderer.
// Signals:
//   p_tick, visible, pixel_x, pixel_y : presented pixel from vga_sync_reg
//   cell_x, cell_y                    : cell address driven to the game core
//   cell_type                         : game core's cell type at (cell_x, cell_y)
//   pal_we, pal_addr, pal_data        : palette write port
//   rgb                               : {R,G,B} colour to the VGA pins
// Modports: master = timing/game side, slave = renderer.
interface tile_grid_renderer_if #(
    parameter int COLS   = 10,
    parameter int ROWS   = 20,
    parameter int TYPE_W = 3
);
    localparam int CXW = COLS > 1 ? $clog2(COLS) : 1;
    localparam int CYW = ROWS > 1 ? $clog2(ROWS) : 1;
    logic              p_tick;
    logic              visible;
    logic [9:0]        pixel_x;
    logic [9:0]        pixel_y;
    logic [CXW-1:0]    cell_x;
    logic [CYW-1:0]    cell_y;
    logic [TYPE_W-1:0] cell_type;
    logic              pal_we;
    logic [TYPE_W-1:0] pal_addr;
    logic [11:0]       pal_data;
    logic [11:0]       rgb;
    modport master (
        output p_tick, visible, pixel_x, pixel_y, cell_type, pal_we, pal_addr, pal_data,
        input  cell_x, cell_y, rgb
    );
    modport slave (
        input  p_tick, visible, pixel_x, pixel_y, cell_type, pal_we, pal_addr, pal_data,
        output cell_x, cell_y, rgb
    );
endinterface

// File: rtl/tile_grid_renderer.sv
// tile_grid_renderer: renders a COLS x ROWS tile board with border, grid lines and a writable palette.
// Ports:
//   clk     : pixel-domain clock
//   reset_n : synchronous active-low reset
//   bus     : tile_grid_renderer_if.slave (pixel stream in, cell address out, cell type in,
//             palette write port, rgb out)
// Pipeline: pixel presented at p_tick n -> cell address after p_tick n+1 -> rgb after p_tick n+2.
// Optional macro TILE_BEVEL_EN: shade non-empty cells lighter on the top/left edge, darker on
// the bottom/right edge.
module tile_grid_renderer #(
    parameter int          ORIGIN_X   = 220,
    parameter int          ORIGIN_Y   = 40,
    parameter int          CELL_W     = 20,
    parameter int          CELL_H     = 20,
    parameter int          COLS       = 10,
    parameter int          ROWS       = 20,
    parameter int          TYPE_W     = 3,
    parameter int          BORDER     = 2,
    parameter logic [11:0] BORDER_RGB = 12'hFFF,
    parameter logic [11:0] GRID_RGB   = 12'h222,
    parameter logic [11:0] BG_RGB     = 12'h000
) (
    input logic clk,
    input logic reset_n,
    tile_grid_renderer_if.slave bus
);
    localparam int CXW   = COLS > 1 ? $clog2(COLS) : 1;
    localparam int CYW   = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int SXW   = $clog2(CELL_W);
    localparam int SYW   = $clog2(CELL_H);
    localparam int X_END = ORIGIN_X + COLS * CELL_W;
    localparam int Y_END = ORIGIN_Y + ROWS * CELL_H;
    localparam int NPAL  = 1 << TYPE_W;

    logic [11:0]    pal [NPAL];
    logic [CXW-1:0] hcol;
    logic [SXW-1:0] hsub;
    logic           in_x;
    logic [CYW-1:0] vrow;
    logic [SYW-1:0] vsub;
    logic           in_y;
    // Coordinates registered on the same p_tick as the counters, so both describe one pixel.
    logic [9:0]     px, py;
    logic           vis0;
    logic           inside1, edge1, border1, vis1;
    logic           h_wrap, v_wrap, border0;
    logic [11:0]    cell_rgb, pix;
`ifdef TILE_BEVEL_EN
    logic [SXW-1:0] hsub1;
    logic [SYW-1:0] vsub1;

    function automatic logic [11:0] shade(logic [11:0] c, logic up);
        logic [11:0] r;
        for (int i = 0; i < 3; i++)
            r[4*i+:4] = up ? (c[4*i+:4] > 4'hB ? 4'hF : c[4*i+:4] + 4'h4)
                           : (c[4*i+:4] < 4'h4 ? 4'h0 : c[4*i+:4] - 4'h4);
        return r;
    endfunction
`endif

    function automatic logic [11:0] pal_default(int i);
        case (i)
            1:       return 12'h09D;
            2:       return 12'h04F;
            3:       return 12'hD90;
            4:       return 12'hFF0;
            5:       return 12'h0F3;
            6:       return 12'h80C;
            7:       return 12'hF00;
            default: return 12'h000;
        endcase
    endfunction

    assign h_wrap = hsub == SXW'(CELL_W - 1);
    assign v_wrap = vsub == SYW'(CELL_H - 1);
    // Border band is the grown rectangle minus the board itself, so a board that has lost
    // counter sync (after a mid-frame reset) shows background, not border.
    assign border0 = int'(px) >= ORIGIN_X - BORDER && int'(px) < X_END + BORDER &&
                     int'(py) >= ORIGIN_Y - BORDER && int'(py) < Y_END + BORDER &&
                     !(int'(px) >= ORIGIN_X && int'(px) < X_END &&
                       int'(py) >= ORIGIN_Y && int'(py) < Y_END);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NPAL; i++) pal[i] <= pal_default(i);
        end else if (bus.pal_we) begin
            pal[bus.pal_addr] <= bus.pal_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hcol <= '0; hsub <= '0; in_x <= 1'b0;
            vrow <= '0; vsub <= '0; in_y <= 1'b0;
            px <= '0; py <= '0; vis0 <= 1'b0;
            bus.cell_x <= '0; bus.cell_y <= '0;
            inside1 <= 1'b0; edge1 <= 1'b0; border1 <= 1'b0; vis1 <= 1'b0;
`ifdef TILE_BEVEL_EN
            hsub1 <= '0; vsub1 <= '0;
`endif
            bus.rgb <= '0;
        end else if (bus.p_tick) begin
            if (bus.pixel_x == 10'(ORIGIN_X)) begin
                hcol <= '0; hsub <= '0; in_x <= 1'b1;
            end else if (in_x) begin
                hsub <= h_wrap ? '0 : hsub + 1'b1;
                if (h_wrap) begin
                    hcol <= hcol == CXW'(COLS - 1) ? '0 : hcol + 1'b1;
                    in_x <= hcol != CXW'(COLS - 1);
                end
            end
            // Vertical counters step once per line, on the line's first pixel.
            if (bus.pixel_x == '0) begin
                if (bus.pixel_y == 10'(ORIGIN_Y)) begin
                    vrow <= '0; vsub <= '0; in_y <= 1'b1;
                end else if (bus.pixel_y == '0) begin
                    in_y <= 1'b0;
                end else if (in_y) begin
                    vsub <= v_wrap ? '0 : vsub + 1'b1;
                    if (v_wrap) begin
                        vrow <= vrow == CYW'(ROWS - 1) ? '0 : vrow + 1'b1;
                        in_y <= vrow != CYW'(ROWS - 1);
                    end
                end
            end
            px <= bus.pixel_x; py <= bus.pixel_y; vis0 <= bus.visible;
            bus.cell_x <= hcol; bus.cell_y <= vrow;
            inside1 <= in_x & in_y;
            edge1   <= hsub == '0 || vsub == '0;
            border1 <= border0;
            vis1    <= vis0;
`ifdef TILE_BEVEL_EN
            hsub1 <= hsub; vsub1 <= vsub;
`endif
            bus.rgb <= pix;
        end
    end

    always_comb begin
        cell_rgb = pal[bus.cell_type];
`ifdef TILE_BEVEL_EN
        if (bus.cell_type != '0 && edge1)
            cell_rgb = shade(cell_rgb, 1'b1);
        else if (bus.cell_type != '0 && (hsub1 == SXW'(CELL_W - 1) || vsub1 == SYW'(CELL_H - 1)))
            cell_rgb = shade(cell_rgb, 1'b0);
`endif
        pix = !vis1                                    ? 12'h000 :
              inside1 && bus.cell_type == '0 && edge1  ? GRID_RGB :
              inside1                                  ? cell_rgb :
              border1                                  ? BORDER_RGB : BG_RGB;
    end
endmodule

// File: tb/tb_tile_grid_renderer.sv
// tb_tile_grid_renderer: raster-driven self-checking bench for tile_grid_renderer.
module tb_tile_grid_renderer;
    localparam int OX = 220, OY = 40, CW = 20, CH = 20, COLS = 10, ROWS = 20, B = 2;
    localparam logic [11:0] PAL0 [8] = '{12'h000, 12'h09D, 12'h04F, 12'hD90,
                                         12'hFF0, 12'h0F3, 12'h80C, 12'hF00};

    typedef struct { bit v; int x; int y; bit vis; bit sync; } hist_t;
    typedef struct { int mode; int x; int y; bit chk_rgb; logic [11:0] rgb; int cx; int cy; } spot_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #10 clk = ~clk;

    tile_grid_renderer_if #(.COLS(COLS), .ROWS(ROWS), .TYPE_W(3)) bus();
    tile_grid_renderer dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

    logic [2:0]  board [ROWS][COLS];
    logic [11:0] pal_m [8];
    spot_t       spots [$];
    hist_t       h1, h2;
    bit          ysync;
    int          mode;
    logic [11:0] last_exp;
    int          n_vec = 0, n_bad = 0;

    // Game-core model: returns the board contents at the address the renderer asks for.
    assign bus.cell_type = (int'(bus.cell_x) < COLS && int'(bus.cell_y) < ROWS) ?
                           board[bus.cell_y][bus.cell_x] : 3'd0;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic bit on_board(hist_t h);
        return h.x >= OX && h.x < OX + COLS*CW && h.y >= OY && h.y < OY + ROWS*CH;
    endfunction

`ifdef TILE_BEVEL_EN
    function automatic logic [11:0] shade(logic [11:0] c, bit up);
        logic [11:0] r;
        for (int i = 0; i < 3; i++) begin
            int v;
            v = int'(c[4*i+:4]);
            v = up ? (v + 4 > 15 ? 15 : v + 4) : (v < 4 ? 0 : v - 4);
            r[4*i+:4] = 4'(v);
        end
        return r;
    endfunction
`endif

    function automatic logic [11:0] model(hist_t h);
        int bx, by, t, hs, vs;
        logic [11:0] c;
        if (!h.v || !h.vis) return 12'h000;
        bx = h.x - OX;
        by = h.y - OY;
        if (on_board(h) && h.sync) begin
            t  = int'(board[by/CH][bx/CW]);
            hs = bx % CW;
            vs = by % CH;
            if (t == 0) return (hs == 0 || vs == 0) ? 12'h222 : pal_m[0];
            c = pal_m[t];
`ifdef TILE_BEVEL_EN
            if (hs == 0 || vs == 0) c = shade(c, 1'b1);
            else if (hs == CW-1 || vs == CH-1) c = shade(c, 1'b0);
`endif
            return c;
        end
        if (!on_board(h) && h.x >= OX-B && h.x < OX+COLS*CW+B && h.y >= OY-B && h.y < OY+ROWS*CH+B)
            return 12'hFFF;
        return 12'h000;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        bus.p_tick = 1'b1;
        bus.pal_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("reset rgb %0d", i), bus.rgb, 12'h000);
        end
        check("reset cell_x", 12'(bus.cell_x), 12'd0);
        check("reset cell_y", 12'(bus.cell_y), 12'd0);
        reset_n = 1'b1;
        h1 = '{0, 0, 0, 0, 0};
        h2 = h1;
        ysync = 0;
        last_exp = 12'h000;
        for (int i = 0; i < 8; i++) pal_m[i] = PAL0[i];
    endtask

    task automatic idle(input bit we, input int a, input logic [11:0] d);
        bus.p_tick = 1'b0;
        bus.pixel_x = $urandom_range(1) ? 10'(OX) : 10'd0;
        bus.pixel_y = 10'(OY);
        bus.pal_we = we; bus.pal_addr = 3'(a); bus.pal_data = d;
        @(posedge clk); #1;
        check("hold rgb", bus.rgb, last_exp);
        if (we) pal_m[a] = d;
        bus.pal_we = 1'b0;
    endtask

    task automatic tick(input int x, input int y, input bit vis, input bit we, input int a,
                        input logic [11:0] d);
        hist_t cur;
        logic [11:0] e;
        bus.pixel_x = 10'(x); bus.pixel_y = 10'(y); bus.visible = vis; bus.p_tick = 1'b1;
        bus.pal_we = we; bus.pal_addr = 3'(a); bus.pal_data = d;
        if (x == 0 && y == OY) ysync = 1;
        cur = '{1, x, y, vis, ysync};
        @(posedge clk); #1;
        e = model(h2);
        check($sformatf("rgb(%0d,%0d)", h2.x, h2.y), bus.rgb, e);
        last_exp = e;
        if (h1.v && h1.sync && on_board(h1)) begin
            check($sformatf("cell_x(%0d,%0d)", h1.x, h1.y), 12'(bus.cell_x), 12'((h1.x - OX) / CW));
            check($sformatf("cell_y(%0d,%0d)", h1.x, h1.y), 12'(bus.cell_y), 12'((h1.y - OY) / CH));
        end
        foreach (spots[i]) begin
            if (spots[i].mode == mode && h2.v && spots[i].chk_rgb && spots[i].x == h2.x && spots[i].y == h2.y)
                check($sformatf("spot rgb(%0d,%0d)", h2.x, h2.y), bus.rgb, spots[i].rgb);
            if (spots[i].mode == mode && h1.v && spots[i].x == h1.x && spots[i].y == h1.y) begin
                if (spots[i].cx >= 0) check($sformatf("spot cell_x(%0d,%0d)", h1.x, h1.y), 12'(bus.cell_x), 12'(spots[i].cx));
                if (spots[i].cy >= 0) check($sformatf("spot cell_y(%0d,%0d)", h1.x, h1.y), 12'(bus.cell_y), 12'(spots[i].cy));
            end
        end
        h2 = h1;
        h1 = cur;
        if (we) pal_m[a] = d;
        bus.pal_we = 1'b0;
    endtask

    task automatic span(input int y, input bit rst_here);
        bit vis, we;
        int a;
        logic [11:0] d;
        for (int x = OX - 6; x <= OX + COLS*CW + 5; x++) begin
            if (mode >= 4 && $urandom_range(7) == 0)
                idle($urandom_range(3) == 0, int'($urandom_range(7)), 12'($urandom));
            vis = mode >= 4 ? ($urandom_range(15) != 0) : !(mode == 0 && y == 50);
            we = 0; a = 0; d = 12'h000;
            if (mode >= 4 && $urandom_range(15) == 0) begin
                we = 1; a = int'($urandom_range(7)); d = 12'($urandom);
            end
            if (mode == 3 && y == 45 && x == 300) begin
                we = 1; a = 3; d = 12'hABC;
            end
            if (rst_here && x == 300) do_reset();
            tick(x, y, vis, we, a, d);
        end
    endtask

    task automatic frame(input int m, input int rst_y);
        mode = m;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                board[r][c] = m < 4 ? 3'(m) : 3'($urandom_range(7));
        for (int y = 0; y < 450; y++) begin
            tick(0, y, 1'b1, 1'b0, 0, 12'h000);
            if (y inside {38, 39, 40, 45, 50, 59, 60, 61, 250, 439, 440, 441, 442, 445} ||
                y == rst_y || (m >= 4 && $urandom_range(15) == 0))
                span(y, y == rst_y);
        end
    endtask

    initial begin
        bus.p_tick = 1'b0; bus.visible = 1'b0; bus.pixel_x = '0; bus.pixel_y = '0;
        bus.pal_we = 1'b0; bus.pal_addr = '0; bus.pal_data = '0;
        spots.push_back('{1, 230,  50, 1, 12'h09D, -1, -1});
        spots.push_back('{1, 217,  45, 1, 12'h000, -1, -1});
        spots.push_back('{1, 218,  45, 1, 12'hFFF, -1, -1});
        spots.push_back('{1, 219,  45, 1, 12'hFFF, -1, -1});
`ifdef TILE_BEVEL_EN
        spots.push_back('{1, 220,  45, 1, 12'h4DF, -1, -1});
        spots.push_back('{1, 419,  45, 1, 12'h059,  9, -1});
        spots.push_back('{2, 240,  45, 1, 12'h48F, -1, -1});
        spots.push_back('{2, 259,  45, 1, 12'h00B, -1, -1});
`else
        spots.push_back('{1, 220,  45, 1, 12'h09D, -1, -1});
        spots.push_back('{1, 419,  45, 1, 12'h09D,  9, -1});
        spots.push_back('{2, 240,  45, 1, 12'h04F, -1, -1});
        spots.push_back('{2, 259,  45, 1, 12'h04F, -1, -1});
`endif
        spots.push_back('{2, 245,  45, 1, 12'h04F, -1, -1});
        spots.push_back('{1, 420,  45, 1, 12'hFFF, -1, -1});
        spots.push_back('{1, 421,  45, 1, 12'hFFF, -1, -1});
        spots.push_back('{1, 422,  45, 1, 12'h000, -1, -1});
        spots.push_back('{1, 239,  45, 0, 12'h000,  0, -1});
        spots.push_back('{1, 240,  45, 0, 12'h000,  1, -1});
        spots.push_back('{1, 230,  59, 0, 12'h000, -1,  0});
        spots.push_back('{1, 230,  60, 0, 12'h000, -1,  1});
        spots.push_back('{1, 230, 439, 0, 12'h000, -1, 19});
        spots.push_back('{1, 230, 440, 1, 12'hFFF, -1, -1});
        spots.push_back('{1, 230, 441, 1, 12'hFFF, -1, -1});
        spots.push_back('{1, 230, 442, 1, 12'h000, -1, -1});
        spots.push_back('{1, 218,  38, 1, 12'hFFF, -1, -1});
        spots.push_back('{1, 217,  38, 1, 12'h000, -1, -1});
        spots.push_back('{0, 240,  45, 1, 12'h222, -1, -1});
        spots.push_back('{0, 241,  45, 1, 12'h000, -1, -1});
        spots.push_back('{0, 241,  60, 1, 12'h222, -1, -1});
        spots.push_back('{0, 240,  50, 1, 12'h000, -1, -1});
        spots.push_back('{3, 298,  45, 1, 12'hD90, -1, -1});
        spots.push_back('{3, 301,  45, 1, 12'hABC, -1, -1});
        mode = 1;
        do_reset();
        frame(1, -1);
        frame(0, -1);
        frame(2, -1);
        frame(3, -1);
        frame(4, 250);
        frame(5, -1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
